nibble_serial_adder16: RTL and testbench
========================================

# nibble_serial_adder16

Multi-cycle 16-bit adder controller that feeds one `fulladder4bit` instance a nibble at a time.
- Latches two 16-bit operands and a carry-in on a start handshake.
- Steps the nibbles LSB-first through the 4-bit ripple adder over four cycles, registering the carry between steps.
- Presents the 16-bit sum, carry-out and signed-overflow flag with a one-cycle done pulse.
- Sits directly upstream of and around the 4-bit adder: it sequences the adder's inputs and consumes its outputs. The arithmetic datapath reuses the existing 4-bit stage instead of a wide adder.

## Interface
Parameters:
- none (width fixed at 16 bits = 4 nibbles).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset; priority over all other inputs.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  16  operand A; sampled on the accepting edge only.
- b  input  16  operand B; sampled on the accepting edge only.
- cin  input  1  carry-in; sampled on the accepting edge only.
- sum  output  16  result; holds the last completed result.
- cout  output  1  carry out of bit 15 of the last completed result.
- ovf  output  1  two's-complement overflow of the last completed result.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse in DONE.

## Operation
Internal state:
- Operand registers a_r and b_r.
- 2-bit nibble index idx.
- Carry register c_r.
- 16-bit partial register p_r.
- FSM with three states: IDLE, RUN, DONE.

Datapath:
- One `fulladder4bit` instance.
- Its inputs are a_r[4*idx+3:4*idx], b_r[4*idx+3:4*idx] and c_r.
- Its outputs are the 4-bit nibble sum and carry-out cn.

FSM:
- IDLE to RUN on start:
  - a_r<=a, b_r<=b, c_r<=cin.
  - idx<=0, p_r<=0.
- IDLE stays in IDLE without start.
- RUN, each edge:
  - p_r nibble idx <= adder sum.
  - c_r<=cn.
  - idx<=idx+1.
- RUN to DONE on the edge where idx==3. The same edge writes the outputs:
  - sum<={adder sum, p_r[11:0]}.
  - cout<=cn.
  - ovf<=(a_r[15]==b_r[15]) && (adder sum[3]!=a_r[15]).
- DONE to RUN if start is high. Operands are accepted exactly as from IDLE, which gives back-to-back operation.
- DONE to IDLE otherwise.

Outputs:
- busy=1 only in RUN.
- done=1 only in DONE. Both are decoded from state, not registered separately.
- start while in RUN is ignored. It is not queued.
- sum, cout and ovf change only on the completing edge. They hold through IDLE, DONE and any later RUN until the next completion.

Arithmetic:
- Unsigned result is {cout,sum} = a + b + cin, mod 2^17.
- ovf follows signed 16-bit semantics including cin. Example: 0x7FFF+0x0000+cin1 gives ovf=1.

Reset:
- Sets state to IDLE.
- Clears sum, cout, ovf, p_r, a_r, b_r, c_r and idx to 0.
- busy and done are 0.
- Reset asserted mid-RUN aborts the operation. No done pulse occurs, and outputs read 0 on the next cycle.

## Timing
- start sampled high at edge k, in IDLE or DONE.
  - busy=1 for the cycles after edges k through k+3.
  - Nibbles 0..3 are computed at edges k+1..k+4.
  - Results are valid and done=1 in the cycle after edge k+4.
- Latency is 5 edges from the accepting edge to done.
- Throughput is one result per 5 cycles when start is held high continuously. DONE accepts the next start.
- The adder path is combinational from registers to c_r/p_r: one 4-bit ripple per cycle.

## Test plan
- Reset, then idle: sum=0x0000, cout=0, ovf=0, busy=0, done=0 for 10 cycles with start=0.
- a=0x1234, b=0x4321, cin=1, start pulse → busy for 4 cycles, then done pulse 5 edges after acceptance; sum=0x5556, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
- Start held high continuously with operands changing every cycle.
  - Only values present on accepting edges (k, k+5, k+10) are used.
  - start pulses during RUN are ignored.
  - done pulses occur at 5-cycle spacing.
- rst asserted one cycle at idx==2 of a run on 0xAAAA+0x5555:
  - next cycle state IDLE, busy=0, sum=0, cout=0.
  - no done pulse; a following 0x0001+0x0001 gives 0x0002.
- Randomised 1000 operations with idle gaps of 0-3 cycles: {cout,sum} equals a+b+cin, and ovf matches the reference sign rule.

Source files
------------

// File: rtl/nibble_serial_adder16.sv
// nibble_serial_adder16 -- 16-bit add done as four 4-bit ripple steps through
// a single fulladder4bit stage, LSB nibble first, carry registered between steps.
//
// Ports:
//   clk    in   clock, all state changes on the rising edge
//   rst    in   synchronous active-high reset, overrides everything
//   start  in   operation request, honoured only in IDLE or DONE
//   a, b   in   16-bit operands, captured on the accepting edge
//   cin    in   carry-in, captured on the accepting edge
//   sum    out  last completed 16-bit sum
//   cout   out  carry out of bit 15 of the last completed result
//   ovf    out  signed overflow of the last completed result
//   busy   out  high while nibbles are being stepped (RUN)
//   done   out  one-cycle pulse once the result is presented (DONE)

// fulladder4bit -- plain 4-bit ripple-carry adder.
//   a_i, b_i  in   4-bit addends
//   cin_i     in   carry-in
//   sum_o     out  4-bit sum
//   cout_o    out  carry out of bit 3
module fulladder4bit (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);
   logic [4:0] c;

   always_comb begin
      c     = '0;
      sum_o = '0;
      c[0]  = cin_i;
      for (int i = 0; i < 4; i++) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
         c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
      end
   end

   assign cout_o = c[4];
endmodule

module nibble_serial_adder16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout,
   output logic        ovf,
   output logic        busy,
   output logic        done
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [15:0] a_q, a_d, b_q, b_d;
   logic        c_q, c_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] p_q, p_d;
   logic [15:0] sum_q, sum_d;
   logic        cout_q, cout_d;
   logic        ovf_q, ovf_d;

   logic [3:0]  nib_a, nib_b, nib_s;
   logic        nib_c;

   // Current nibble selected by idx; {idx,2'b00} is the nibble's LSB position.
   assign nib_a = a_q[{idx_q, 2'b00} +: 4];
   assign nib_b = b_q[{idx_q, 2'b00} +: 4];

   fulladder4bit u_fa4 (
      .a_i    (nib_a),
      .b_i    (nib_b),
      .cin_i  (c_q),
      .sum_o  (nib_s),
      .cout_o (nib_c)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      idx_d   = idx_q;
      p_d     = p_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            // DONE accepts a new start exactly like IDLE (back-to-back ops).
            if (start) begin
               state_d = S_RUN;
               a_d     = a;
               b_d     = b;
               c_d     = cin;
               idx_d   = 2'd0;
               p_d     = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            p_d[{idx_q, 2'b00} +: 4] = nib_s;
            c_d   = nib_c;
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               state_d = S_DONE;
               sum_d   = {nib_s, p_q[11:0]};
               cout_d  = nib_c;
               // Signed overflow: like-signed operands giving an unlike-signed sum.
               ovf_d   = (a_q[15] == b_q[15]) && (nib_s[3] != a_q[15]);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         idx_q   <= '0;
         p_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         idx_q   <= idx_d;
         p_q     <= p_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
endmodule

// File: tb/tb_nibble_serial_adder16.sv
// Scoreboard bench for nibble_serial_adder16: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_nibble_serial_adder16;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic        cin = 1'b0;
   logic [15:0] sum;
   logic        cout, ovf, busy, done;

   typedef struct packed {
      logic [15:0] s;
      logic        c;
      logic        o;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   nibble_serial_adder16 dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic exp_t ref_add(input logic [15:0] x, input logic [15:0] y, input logic c);
      exp_t       e;
      logic [16:0] r;
      r   = {1'b0, x} + {1'b0, y} + {16'd0, c};
      e.s = r[15:0];
      e.c = r[16];
      e.o = (x[15] == y[15]) && (r[15] != x[15]);
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sum", {16'd0, sum}, {16'd0, e.s});
            chk("cout", {31'd0, cout}, {31'd0, e.c});
            chk("ovf", {31'd0, ovf}, {31'd0, e.o});
         end
      end
   end

   // Issue one operation and wait (bounded) for its done pulse.
   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        input exp_t e, input bit chk_t);
      int n;
      @(negedge clk);
      a = ta; b = tb_; cin = tc; start = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!done && n < 10) begin
         if (chk_t) chk("busy_run", {31'd0, busy}, 32'd1);
         @(negedge clk);
         n++;
      end
      if (chk_t) chk("latency", n, 32'd5);
      if (!done) chk("done_timeout", 32'd0, 32'd1);
      else if (chk_t) chk("busy_in_done", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      exp_t e;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset / idle state over 10 cycles.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("reset_idle", {sum, cout, ovf, busy, done}, 32'd0);
      end

      // Directed vectors with hand-computed results.
      e = '{16'h5556, 1'b0, 1'b0}; do_op(16'h1234, 16'h4321, 1'b1, e, 1'b1);
      @(negedge clk);
      chk("hold_idle", {15'd0, sum, cout}, {15'd0, 16'h5556, 1'b0});
      chk("idle_flags", {30'd0, busy, done}, 32'd0);
      e = '{16'h0000, 1'b1, 1'b0}; do_op(16'hFFFF, 16'h0001, 1'b0, e, 1'b1);
      e = '{16'h8000, 1'b0, 1'b1}; do_op(16'h7FFF, 16'h0001, 1'b0, e, 1'b1);
      e = '{16'h0000, 1'b1, 1'b1}; do_op(16'h8000, 16'h8000, 1'b0, e, 1'b1);
      e = '{16'h8000, 1'b0, 1'b1}; do_op(16'h7FFF, 16'h0000, 1'b1, e, 1'b1);
      e = '{16'h0000, 1'b1, 1'b0}; do_op(16'hFFFF, 16'h0000, 1'b1, e, 1'b0);
      repeat (3) @(negedge clk);

      // start held high, operands change every cycle; only edges k, k+5, k+10 accept.
      for (int n = 0; n < 15; n++) begin
         logic [15:0] va, vb;
         logic        vc;
         @(negedge clk);
         if (n > 0) chk("stream_done", {31'd0, done}, (n == 5 || n == 10) ? 32'd1 : 32'd0);
         va = 16'(n * 16'h0111);
         vb = 16'h0F00 + 16'(n);
         vc = n[0];
         a = va; b = vb; cin = vc; start = 1'b1;
         if (n % 5 == 0) sb.push_back(ref_add(va, vb, vc));
      end
      @(negedge clk);
      start = 1'b0;
      chk("stream_done", {31'd0, done}, 32'd1);
      repeat (2) @(negedge clk);

      // Reset while idx==2 of 0xAAAA+0x5555 aborts with no done pulse.
      @(negedge clk);
      a = 16'hAAAA; b = 16'h5555; cin = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("abort_state", {sum, cout, ovf, busy, done}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_no_done", {31'd0, done}, 32'd0);
      end
      e = '{16'h0002, 1'b0, 1'b0}; do_op(16'h0001, 16'h0001, 1'b0, e, 1'b1);

      // Randomised operations with idle gaps of 0-3 cycles.
      for (int i = 0; i < 1000; i++) begin
         logic [15:0] ra, rb;
         logic        rc;
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_op(ra, rb, rc, ref_add(ra, rb, rc), 1'b0);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
